// File: rtl/mac_sched_pkg.sv
// Shared types and default sizing for the chunked dot-product scheduler.
package mac_sched_pkg;

  localparam int unsigned MAX_MACS_DEF   = 64;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ACC_WIDTH_DEF  = 32;
  localparam int unsigned CHUNK_IDX_W    = 5;
  localparam int unsigned VEC_LEN_W      = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/mac_sched.sv
// Splits a dot product into MAX_MACS-wide chunks, issues each to an external
// mac datapath and accumulates the signed partial results.
module mac_sched
  import mac_sched_pkg::*;
#(
  parameter int unsigned MAX_MACS   = MAX_MACS_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ACC_WIDTH  = ACC_WIDTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic [VEC_LEN_W-1:0]           vec_len_i,
  output logic                           busy_o,
  output logic                           chunk_req_o,
  output logic [CHUNK_IDX_W-1:0]         chunk_idx_o,
  input  logic                           chunk_valid_i,
  input  logic [MAX_MACS*DATA_WIDTH-1:0] data_i,
  input  logic [MAX_MACS*DATA_WIDTH-1:0] weight_i,
  output logic [VEC_LEN_W-1:0]           mac_num_o,
  output logic                           mac_valid_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0] mac_data_o,
  output logic [MAX_MACS*DATA_WIDTH-1:0] mac_weight_o,
  input  logic [2*DATA_WIDTH-1:0]        mac_out_i,
  input  logic                           mac_valid_i,
  output logic [ACC_WIDTH-1:0]           result_o,
  output logic                           result_valid_o,
  input  logic                           result_ready_i
);

  localparam int unsigned LANES_W = MAX_MACS * DATA_WIDTH;
  localparam int unsigned PART_W  = 2 * DATA_WIDTH;
  localparam int unsigned EXT_W   = ACC_WIDTH - PART_W;
  localparam logic [VEC_LEN_W-1:0] MAX_MACS_V = VEC_LEN_W'(MAX_MACS);

  state_e                 state_q, state_d;
  logic [VEC_LEN_W-1:0]   rem_q, rem_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [CHUNK_IDX_W-1:0] idx_q, idx_d;
  logic [VEC_LEN_W-1:0]   num_q, num_d;
  logic [LANES_W-1:0]     data_q, data_d;
  logic [LANES_W-1:0]     wgt_q, wgt_d;
  logic                   busy_q, req_q, mvalid_q, rvalid_q;
  logic [ACC_WIDTH-1:0]   part_ext;

  assign part_ext = {{EXT_W{mac_out_i[PART_W-1]}}, mac_out_i};

  // Next-state and datapath updates
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    num_d   = num_q;
    data_d  = data_q;
    wgt_d   = wgt_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          rem_d   = vec_len_i;
          acc_d   = '0;
          idx_d   = '0;
          state_d = (vec_len_i != '0) ? ST_FETCH : ST_DONE;
        end
      end
      ST_FETCH: begin
        if (chunk_valid_i) begin
          data_d  = data_i;
          wgt_d   = weight_i;
          num_d   = (rem_q < MAX_MACS_V) ? rem_q : MAX_MACS_V;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mac_valid_i) begin
          acc_d   = acc_q + part_ext;
          rem_d   = rem_q - num_q;
          idx_d   = idx_q + CHUNK_IDX_W'(1);
          state_d = (rem_q == num_q) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        if (result_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Status strobes are registered from the next state so they track the FSM exactly
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      rem_q    <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      num_q    <= '0;
      data_q   <= '0;
      wgt_q    <= '0;
      busy_q   <= 1'b0;
      req_q    <= 1'b0;
      mvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      data_q   <= data_d;
      wgt_q    <= wgt_d;
      busy_q   <= (state_d != ST_IDLE);
      req_q    <= (state_d == ST_FETCH);
      mvalid_q <= (state_d == ST_ISSUE);
      rvalid_q <= (state_d == ST_DONE);
    end
  end

  assign busy_o         = busy_q;
  assign chunk_req_o    = req_q;
  assign chunk_idx_o    = idx_q;
  assign mac_num_o      = num_q;
  assign mac_valid_o    = mvalid_q;
  assign mac_data_o     = data_q;
  assign mac_weight_o   = wgt_q;
  assign result_o       = acc_q;
  assign result_valid_o = rvalid_q;

endmodule

// File: tb/tb_mac_sched.sv
// Directed bench for mac_sched: drives chunk and mac handshakes by hand.
module tb_mac_sched;

  localparam int unsigned LW = 512;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_i = 1'b0;
  logic [10:0]     vec_len_i = '0;
  logic            busy_o, chunk_req_o, mac_valid_o, result_valid_o;
  logic [4:0]      chunk_idx_o;
  logic            chunk_valid_i = 1'b0;
  logic [LW-1:0]   data_i = '0, weight_i = '0;
  logic [10:0]     mac_num_o;
  logic [LW-1:0]   mac_data_o, mac_weight_o;
  logic [15:0]     mac_out_i = '0;
  logic            mac_valid_i = 1'b0;
  logic [31:0]     result_o;
  logic            result_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  mac_sched dut (
    .clk(clk), .rst(rst), .start_i(start_i), .vec_len_i(vec_len_i),
    .busy_o(busy_o), .chunk_req_o(chunk_req_o), .chunk_idx_o(chunk_idx_o),
    .chunk_valid_i(chunk_valid_i), .data_i(data_i), .weight_i(weight_i),
    .mac_num_o(mac_num_o), .mac_valid_o(mac_valid_o),
    .mac_data_o(mac_data_o), .mac_weight_o(mac_weight_o),
    .mac_out_i(mac_out_i), .mac_valid_i(mac_valid_i),
    .result_o(result_o), .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, LW'(busy_o), '0);
    check({tag, " req"}, LW'(chunk_req_o), '0);
    check({tag, " idx"}, LW'(chunk_idx_o), '0);
    check({tag, " num"}, LW'(mac_num_o), '0);
    check({tag, " mvalid"}, LW'(mac_valid_o), '0);
    check({tag, " mdata"}, mac_data_o, '0);
    check({tag, " mweight"}, mac_weight_o, '0);
    check({tag, " result"}, LW'(result_o), '0);
    check({tag, " rvalid"}, LW'(result_valid_o), '0);
  endtask

  task automatic start_job(input logic [10:0] len);
    start_i   = 1'b1;
    vec_len_i = len;
    tick();
    start_i   = 1'b0;
    check("start busy", LW'(busy_o), LW'(1));
  endtask

  // One chunk: FETCH (with stray mac_valid_i), then ISSUE (with stray chunk_valid_i)
  task automatic fetch_chunk(input logic [4:0] idx, input logic [10:0] num, input int fwait);
    logic [LW-1:0] d, w;
    check("fetch req", LW'(chunk_req_o), LW'(1));
    check("fetch idx", LW'(chunk_idx_o), LW'(idx));
    check("fetch mvalid", LW'(mac_valid_o), '0);
    for (int i = 0; i < fwait; i++) begin
      mac_valid_i = 1'b1;
      mac_out_i   = 16'h7fff;
      tick();
      check("fetch hold req", LW'(chunk_req_o), LW'(1));
      check("fetch hold idx", LW'(chunk_idx_o), LW'(idx));
    end
    mac_valid_i = 1'b0;
    for (int i = 0; i < LW / 32; i++) begin
      d[i*32 +: 32] = $urandom;
      w[i*32 +: 32] = $urandom;
    end
    data_i = d;
    weight_i = w;
    chunk_valid_i = 1'b1;
    tick();
    chunk_valid_i = 1'b0;
    check("issue mvalid", LW'(mac_valid_o), LW'(1));
    check("issue num", LW'(mac_num_o), LW'(num));
    check("issue data", mac_data_o, d);
    check("issue weight", mac_weight_o, w);
    check("issue req", LW'(chunk_req_o), '0);
  endtask

  task automatic finish_chunk(input logic [15:0] part, input int lat);
    logic [LW-1:0] d;
    d = mac_data_o;
    for (int i = 0; i < lat; i++) begin
      chunk_valid_i = 1'b1;
      data_i = ~data_i;
      tick();
      check("issue hold mvalid", LW'(mac_valid_o), LW'(1));
      check("issue hold data", mac_data_o, d);
    end
    chunk_valid_i = 1'b0;
    mac_valid_i = 1'b1;
    mac_out_i   = part;
    tick();
    mac_valid_i = 1'b0;
    check("post issue mvalid", LW'(mac_valid_o), '0);
  endtask

  task automatic expect_result(input logic [31:0] res);
    check("done rvalid", LW'(result_valid_o), LW'(1));
    check("done result", LW'(result_o), LW'(res));
    check("done req", LW'(chunk_req_o), '0);
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check("idle busy", LW'(busy_o), '0);
    check("idle rvalid", LW'(result_valid_o), '0);
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Single element, negative partial
    start_job(11'd1);
    fetch_chunk(5'd0, 11'd1, 0);
    finish_chunk(16'hff9d, 0);
    expect_result(32'hffff_ff9d);

    // One full chunk plus a single-lane tail; stray handshakes ignored
    start_job(11'd65);
    fetch_chunk(5'd0, 11'd64, 2);
    finish_chunk(16'd100, 3);
    fetch_chunk(5'd1, 11'd1, 1);
    finish_chunk(16'hfffd, 1);
    expect_result(32'd97);

    // Maximum length: 32 chunks, last one 63 lanes
    start_job(11'd2047);
    for (int c = 0; c < 32; c++) begin
      fetch_chunk(5'(c), (c == 31) ? 11'd63 : 11'd64, 0);
      finish_chunk(16'd1000, c % 2);
    end
    expect_result(32'd32000);

    // Zero length goes straight to DONE one cycle after start
    start_job(11'd0);
    check("zero mvalid", LW'(mac_valid_o), '0);
    expect_result(32'd0);

    // Consumer stalls; a start pulse while busy must be ignored
    start_job(11'd3);
    fetch_chunk(5'd0, 11'd3, 0);
    finish_chunk(16'd7, 0);
    for (int i = 0; i < 5; i++) begin
      start_i   = (i == 2);
      vec_len_i = 11'd10;
      tick();
      check("stall rvalid", LW'(result_valid_o), LW'(1));
      check("stall result", LW'(result_o), LW'(7));
    end
    start_i = 1'b0;
    expect_result(32'd7);
    tick();
    check("start ignored busy", LW'(busy_o), '0);

    // Reset while issuing the second of three chunks
    start_job(11'd150);
    fetch_chunk(5'd0, 11'd64, 0);
    finish_chunk(16'd100, 0);
    fetch_chunk(5'd1, 11'd64, 0);
    #2 rst = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("post reset busy", LW'(busy_o), '0);
    start_job(11'd64);
    fetch_chunk(5'd0, 11'd64, 1);
    finish_chunk(16'hfb2e, 2);
    expect_result(32'hffff_fb2e);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 SHALL have parameters: MAX_MACS, default 64, lanes per MAC issue; DATA_WIDTH, default 8, operand width; ACC_WIDTH, default 32, accumulator width.
REQ-002 SHALL have one clock and an asynchronous, active-low reset, named clk and rst.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst  input  1  asynchronous active-low reset.
REQ-005 start_i  input  1  one-cycle dot-product request; accepted only in IDLE.
REQ-006 vec_len_i  input  11  total element count, 0..2047, sampled with start_i.
REQ-007 busy_o  output  1  high in every state except IDLE.
REQ-008 chunk_req_o  output  1  operand chunk request.
REQ-009 chunk_idx_o  output  5  index of the requested chunk.
REQ-010 chunk_valid_i  input  1  operand chunk present on data_i/weight_i.
REQ-011 data_i, weight_i  input  MAX_MACS*DATA_WIDTH  flattened signed operands; lane i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 mac_num_o  output  11  lane count for the mac datapath.
REQ-013 mac_valid_o  output  1  mac datapath valid_in.
REQ-014 mac_data_o, mac_weight_o  output  MAX_MACS*DATA_WIDTH  registered operands to the mac.
REQ-015 mac_out_i  input  2*DATA_WIDTH  signed partial result from the mac.
REQ-016 mac_valid_i  input  1  mac datapath valid_out.
REQ-017 result_o  output  ACC_WIDTH  signed dot-product result.
REQ-018 result_valid_o  output  1  result available.
REQ-019 result_ready_i  input  1  consumer accepts result.

Function
REQ-020 SHALL implement the states IDLE, FETCH, ISSUE, DONE.
REQ-021 IDLE with start_i=1: latch remaining=vec_len_i, clear the accumulator, set chunk_idx=0; go to FETCH if vec_len_i!=0, otherwise go to DONE with result_o=0.
REQ-022 FETCH: chunk_req_o=1 with chunk_idx_o stable; when chunk_valid_i=1, register data_i/weight_i into mac_data_o/mac_weight_o, set mac_num_o=min(remaining,MAX_MACS), and go to ISSUE on the next cycle.
REQ-023 ISSUE: hold mac_valid_o=1, with operands and mac_num_o stable, until mac_valid_i=1 is sampled.
REQ-024 On mac_valid_i=1 in ISSUE: add sign-extended mac_out_i to the accumulator, subtract mac_num_o from remaining, increment chunk_idx, and drop mac_valid_o the next cycle.
REQ-025 After that update: go to DONE if remaining is 0, otherwise go to FETCH; mac_valid_o SHALL stay low for at least 1 cycle between issues.
REQ-026 DONE: result_valid_o=1 and result_o stable until result_ready_i=1; on that handshake go to IDLE the next cycle.
REQ-027 start_i outside IDLE SHALL be ignored.
REQ-028 mac_valid_i outside ISSUE, and chunk_valid_i outside FETCH, SHALL be ignored.
REQ-029 Lanes at or above mac_num_o in the final partial chunk are don't-care; the mac masks them using mac_num_o.
REQ-030 The accumulator SHALL not overflow: at most 32 chunks of 16-bit partials fit in 21 bits, which is below ACC_WIDTH.
REQ-031 Latency from start_i to result_valid_o SHALL be, per chunk, (fetch wait + 1 + mac latency + 1) cycles, plus 1 cycle.
REQ-032 vec_len=0 SHALL give result_valid_o 1 cycle after start_i.

Reset
REQ-033 rst=0 SHALL immediately force IDLE with all outputs 0 (busy_o, chunk_req_o, chunk_idx_o, mac_num_o, mac_valid_o, mac_data_o, mac_weight_o, result_o, result_valid_o) and clear the accumulator and remaining.
REQ-034 Reset mid-operation SHALL abandon the job with no result; the first post-reset start_i SHALL behave as from power-up.

Structure
REQ-035 Shared package mac_sched_pkg SHALL hold the state enum, default MAX_MACS/DATA_WIDTH/ACC_WIDTH, and the chunk-index width constant (5).
REQ-036 SHALL be a single flat module with no sub-modules; the mac datapath is instantiated alongside it by the parent, not inside it.

Verification
REQ-037 vec_len=1, chunk valid immediately, mac returns -99 -> mac_num_o=1, one chunk_idx=0 request, result_o=-99.
REQ-038 vec_len=65, mac returns 100 then -3 -> chunk_idx 0 then 1, mac_num_o 64 then 1, result_o=97.
REQ-039 vec_len=2047, mac returns 1000 each chunk -> 32 requests (idx 0..31), last mac_num_o=63, result_o=32000.
REQ-040 vec_len=0 -> no chunk_req_o, no mac_valid_o, result_valid_o 1 cycle after start_i, result_o=0.
REQ-041 result_ready_i held low 5 cycles in DONE; start_i pulsed while busy -> result stays stable, start ignored, IDLE only after ready.
REQ-042 rst asserted while in ISSUE on chunk 2 of 3 -> all outputs 0 immediately; a new vec_len=64 job then completes correctly.
